// File: rtl/mouse_cell_tracker_pkg.sv
// Shared constants, PS/2 header layout and state encodings for the mouse front end.
package mouse_cell_tracker_pkg;

  localparam int SCREEN_WIDTH_DEF   = 320;
  localparam int SCREEN_HEIGHT_DEF  = 240;
  localparam int CELL_DIMENSION_DEF = 5;

  function automatic int clog2_max(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

  localparam int CELLS_X    = SCREEN_WIDTH_DEF / CELL_DIMENSION_DEF;
  localparam int CELLS_Y    = SCREEN_HEIGHT_DEF / CELL_DIMENSION_DEF;
  localparam int UPPER_BITS = clog2_max(CELLS_X, CELLS_Y);
  localparam int ACC_W      = 10;

  localparam int YOVF  = 7;
  localparam int XOVF  = 6;
  localparam int YSIGN = 5;
  localparam int XSIGN = 4;
  localparam int SYNC  = 3;
  localparam int RIGHT = 1;
  localparam int LEFT  = 0;

  typedef enum logic [1:0] {B0, B1, B2} rx_state_e;
  typedef enum logic [1:0] {IDLE, LOAD, STEP} step_state_e;

  // Overflowed axes saturate to the extremes of the 9-bit range.
  function automatic logic signed [8:0] axis_delta(input logic ovf, input logic sgn,
                                                   input logic [7:0] mag);
    if (ovf) return sgn ? 9'sh100 : 9'sh0FF;
    return {sgn, mag};
  endfunction

endpackage

// File: rtl/mouse_cell_tracker_ps2_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets into signed deltas and button levels.
// Optional inter-byte resync timeout under MOUSE_TIMEOUT_EN.
module ps2_packet_assembler
  import mouse_cell_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              iClk,
  input  logic              iResetn,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic signed [8:0] dx_o,
  output logic signed [8:0] dy_o,
  output logic [1:0]        buttons_o,
  output logic              pkt_done_o
);

  rx_state_e         state_q;
  logic [7:0]        hdr_q;
  logic [7:0]        x_q;
  logic signed [8:0] dx_q;
  logic signed [8:0] dy_q;
  logic [1:0]        btn_q;
  logic              done_q;
  logic              timeout_hit;

`ifdef MOUSE_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_q;

  assign timeout_hit = (state_q != B0) && !byte_valid_i &&
                       (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn)
      gap_q <= '0;
    else if (byte_valid_i || (state_q == B0) || timeout_hit)
      gap_q <= '0;
    else
      gap_q <= gap_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  // Keeps the timeout parameter referenced when the feature is compiled out.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_degenerate
  end
`endif

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= B0;
      hdr_q   <= '0;
      x_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      btn_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (byte_valid_i) begin
        case (state_q)
          B0: if (byte_i[SYNC]) begin
            hdr_q   <= byte_i;
            state_q <= B1;
          end
          B1: begin
            x_q     <= byte_i;
            state_q <= B2;
          end
          B2: begin
            dx_q    <= axis_delta(hdr_q[XOVF], hdr_q[XSIGN], x_q);
            dy_q    <= axis_delta(hdr_q[YOVF], hdr_q[YSIGN], byte_i);
            btn_q   <= {hdr_q[RIGHT], hdr_q[LEFT]};
            done_q  <= 1'b1;
            state_q <= B0;
          end
          default: state_q <= B0;
        endcase
      end else if (timeout_hit) begin
        state_q <= B0;
      end
    end
  end

  assign dx_o       = dx_q;
  assign dy_o       = dy_q;
  assign buttons_o  = btn_q;
  assign pkt_done_o = done_q;

endmodule

// File: rtl/mouse_cell_tracker.sv
// PS/2 mouse to grid-cell tracker: packet assembly, count accumulation and clamped cell stepping.
// Build option MOUSE_TIMEOUT_EN enables the inter-byte resync timeout in the assembler.
module mouse_cell_tracker
  import mouse_cell_tracker_pkg::*;
#(
  parameter int SCREEN_WIDTH   = 320,
  parameter int SCREEN_HEIGHT  = 240,
  parameter int CELL_DIMENSION = 5,
  parameter int CELL_COUNTS    = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  iClk,
  input  logic                  iResetn,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic [UPPER_BITS-1:0] oX_cell,
  output logic [UPPER_BITS-1:0] oY_cell,
  output logic                  oLeft,
  output logic                  oRight,
  output logic                  oUpdate,
  output logic                  oDrop
);

  localparam int CELLS_X_L = SCREEN_WIDTH / CELL_DIMENSION;
  localparam int CELLS_Y_L = SCREEN_HEIGHT / CELL_DIMENSION;
  localparam logic signed [ACC_W-1:0] CNT_S = ACC_W'(CELL_COUNTS);

  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic [1:0]        buttons;
  logic              pkt_done;

  ps2_packet_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_assembler (
    .iClk        (iClk),
    .iResetn     (iResetn),
    .byte_i      (iByte),
    .byte_valid_i(iByteValid),
    .dx_o        (dx),
    .dy_o        (dy),
    .buttons_o   (buttons),
    .pkt_done_o  (pkt_done)
  );

  step_state_e              state_q;
  logic signed [ACC_W-1:0]  acc_q   [2];
  logic [UPPER_BITS-1:0]    cell_q  [2];
  logic [1:0]               shadow_q;
  logic                     left_q, right_q, upd_q, drop_q;

  logic signed [ACC_W-1:0]  delta_w [2];
  logic signed [ACC_W-1:0]  acc_d   [2];
  logic [UPPER_BITS-1:0]    cell_d  [2];
  logic [UPPER_BITS-1:0]    limit   [2];
  logic [1:0]               settled;
  logic [1:0]               btn_now;

  // Screen Y grows downward while mouse Y grows upward.
  assign delta_w[0] = ACC_W'(dx);
  assign delta_w[1] = -ACC_W'(dy);
  assign limit[0]   = UPPER_BITS'(CELLS_X_L - 1);
  assign limit[1]   = UPPER_BITS'(CELLS_Y_L - 1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic                    up, dn, at_hi, at_lo;
    logic signed [ACC_W-1:0] acc_step;
    logic [UPPER_BITS-1:0]   cell_step;

    assign up    = acc_q[gi] >= CNT_S;
    assign dn    = acc_q[gi] <= -CNT_S;
    assign at_hi = cell_q[gi] == limit[gi];
    assign at_lo = cell_q[gi] == '0;

    // A step blocked by the grid edge discards the residual counts on that axis.
    assign acc_step  = up ? (at_hi ? '0 : acc_q[gi] - CNT_S) :
                       dn ? (at_lo ? '0 : acc_q[gi] + CNT_S) : acc_q[gi];
    assign cell_step = (up && !at_hi) ? cell_q[gi] + 1'b1 :
                       (dn && !at_lo) ? cell_q[gi] - 1'b1 : cell_q[gi];

    assign acc_d[gi]   = (state_q == LOAD) ? acc_q[gi] + delta_w[gi] : acc_step;
    assign cell_d[gi]  = (state_q == STEP) ? cell_step : cell_q[gi];
    assign settled[gi] = (acc_d[gi] < CNT_S) && (acc_d[gi] > -CNT_S);
  end

  assign btn_now = (state_q == LOAD) ? buttons : shadow_q;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      upd_q    <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        acc_q[i]  <= '0;
        cell_q[i] <= '0;
      end
    end else begin
      upd_q  <= 1'b0;
      drop_q <= pkt_done && (state_q != IDLE);
      case (state_q)
        IDLE: if (pkt_done) state_q <= LOAD;
        LOAD, STEP: begin
          for (int i = 0; i < 2; i++) begin
            acc_q[i]  <= acc_d[i];
            cell_q[i] <= cell_d[i];
          end
          if (state_q == LOAD) shadow_q <= buttons;
          if (&settled) begin
            left_q  <= btn_now[0];
            right_q <= btn_now[1];
            upd_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= STEP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oX_cell = cell_q[0];
  assign oY_cell = cell_q[1];
  assign oLeft   = left_q;
  assign oRight  = right_q;
  assign oUpdate = upd_q;
  assign oDrop   = drop_q;

endmodule

// File: tb/tb_mouse_cell_tracker.sv
// Directed bench for mouse_cell_tracker: packet framing, stepping, clamping, drops and resync.
module tb_mouse_cell_tracker;

  logic       iClk = 1'b0;
  logic       iResetn = 1'b0;
  logic [7:0] iByte = 8'h00;
  logic       iByteValid = 1'b0;
  logic [5:0] oX_cell, oY_cell;
  logic       oLeft, oRight, oUpdate, oDrop;

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;
  int drop_cnt = 0;
  int upd_base, drop_base;

  mouse_cell_tracker #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iByte     (iByte),
    .iByteValid(iByteValid),
    .oX_cell   (oX_cell),
    .oY_cell   (oY_cell),
    .oLeft     (oLeft),
    .oRight    (oRight),
    .oUpdate   (oUpdate),
    .oDrop     (oDrop)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    if (oUpdate === 1'b1) upd_cnt++;
    if (oDrop === 1'b1) drop_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge iClk);
    iByte = b;
    iByteValid = 1'b1;
    @(negedge iClk);
    iByteValid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic wait_update(input string tag);
    int n = 0;
    while (oUpdate !== 1'b1 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check(tag, {15'd0, oUpdate}, 16'd1);
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iResetn = 1'b0;
    idle(2);
    iResetn = 1'b1;
    idle(2);
  endtask

  initial begin
    // Reset and idle
    idle(3);
    iResetn = 1'b1;
    idle(10);
    check("rst_x", oX_cell, 0);
    check("rst_y", oY_cell, 0);
    check("rst_left", oLeft, 0);
    check("rst_right", oRight, 0);
    check("rst_no_update", upd_cnt, 0);
    check("rst_no_drop", drop_cnt, 0);
    $display("[TB] reset/idle checked");

    // dx=+16: two steps, oUpdate exactly four edges after the Y byte is sampled
    send_pkt(8'h08, 8'h10, 8'h00);
    idle(1);
    check("lat_e1", oUpdate, 0);
    idle(1);
    check("lat_e2", oUpdate, 0);
    idle(1);
    check("lat_e3", oUpdate, 0);
    idle(1);
    check("lat_e4", oUpdate, 1);
    check("dx16_x", oX_cell, 2);
    check("dx16_y", oY_cell, 0);
    send_pkt(8'h08, 8'h07, 8'h00);
    wait_update("dx7_upd");
    check("dx7_acc_was_zero", oX_cell, 2);
    $display("[TB] packet 08 10 00 -> x=%0d y=%0d", oX_cell, oY_cell);

    // Y inversion and top-edge clamp
    do_reset();
    send_pkt(8'h28, 8'h00, 8'hF0);
    wait_update("dyn16_upd");
    check("dyn16_y", oY_cell, 2);
    check("dyn16_x", oX_cell, 0);
    send_pkt(8'h08, 8'h00, 8'h18);
    wait_update("dy24_upd");
    check("dy24_clamp_y", oY_cell, 0);
    send_pkt(8'h28, 8'h00, 8'hF8);
    wait_update("dyn8_upd");
    check("dyn8_accy_zeroed", oY_cell, 1);
    $display("[TB] y inversion/clamp -> y=%0d", oY_cell);

    // Sync-bit resync, button levels, residual accumulator
    do_reset();
    upd_base = upd_cnt;
    send_byte(8'h00);
    send_pkt(8'h09, 8'h05, 8'h00);
    wait_update("btn_upd");
    check("btn_left", oLeft, 1);
    check("btn_right", oRight, 0);
    check("btn_x", oX_cell, 0);
    idle(3);
    check("btn_one_update", upd_cnt - upd_base, 1);
    send_pkt(8'h08, 8'h03, 8'h00);
    wait_update("acc5_upd");
    check("acc5_x", oX_cell, 1);
    check("acc5_left", oLeft, 0);
    send_pkt(8'h0A, 8'h00, 8'h00);
    wait_update("rbtn_upd");
    check("rbtn_right", oRight, 1);
    check("rbtn_left", oLeft, 0);
    $display("[TB] resync/buttons -> x=%0d L=%0d R=%0d", oX_cell, oLeft, oRight);

    // X overflow saturation to the right edge, then negative overflow
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_pkt(8'h48, 8'hFF, 8'h00);
      wait_update("ovf_upd");
    end
    check("ovf_x63", oX_cell, 63);
    check("ovf_y", oY_cell, 0);
    send_pkt(8'h58, 8'h00, 8'h00);
    wait_update("novf_upd");
    check("novf_x31", oX_cell, 31);
    $display("[TB] overflow saturation -> x=%0d", oX_cell);

    // Packet completing during STEP is dropped
    do_reset();
    upd_base = upd_cnt;
    drop_base = drop_cnt;
    send_pkt(8'h08, 8'h40, 8'h00);
    send_pkt(8'h08, 8'h40, 8'h00);
    idle(30);
    check("drop_pulses", drop_cnt - drop_base, 1);
    check("drop_updates", upd_cnt - upd_base, 1);
    check("drop_x", oX_cell, 8);
    $display("[TB] busy drop -> x=%0d drops=%0d", oX_cell, drop_cnt - drop_base);

    // Reset mid-packet loses the partial packet
    send_byte(8'h08);
    send_byte(8'h10);
    do_reset();
    send_pkt(8'h08, 8'h08, 8'h00);
    wait_update("midrst_upd");
    check("midrst_x", oX_cell, 1);
    $display("[TB] mid-packet reset -> x=%0d", oX_cell);

    // Inter-byte gap: resynced with the timeout, misaligned without it
    do_reset();
    upd_base = upd_cnt;
    send_byte(8'h08);
    send_byte(8'h10);
    idle(60);
    send_pkt(8'h08, 8'h08, 8'h00);
    idle(40);
    check("gap_updates", upd_cnt - upd_base, 1);
`ifdef MOUSE_TIMEOUT_EN
    check("gap_x", oX_cell, 1);
`else
    check("gap_x", oX_cell, 2);
`endif
    check("gap_y", oY_cell, 0);
    $display("[TB] inter-byte gap -> x=%0d y=%0d", oX_cell, oY_cell);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mouse_cell_tracker.md
Name: mouse_cell_tracker

Overview:
- Upstream stage of the drawing datapath.
- Consumes raw bytes from the PS/2 receiver and assembles the standard 3-byte mouse packets.
- Accumulates movement counts into cell coordinates on the 64x48 grid (320x240 screen, 5-pixel cells), clamped to the grid edges.
- Drives the datapath's cell inputs and supplies the left/right button levels to the drawing FSM.

Parameters:
- SCREEN_WIDTH, 320, screen width in pixels
- SCREEN_HEIGHT, 240, screen height in pixels
- CELL_DIMENSION, 5, pixels per cell edge
- CELL_COUNTS, 8, mouse counts per one-cell move (2..128)
- TIMEOUT_CYCLES, 100000, maximum inter-byte gap before resync (used only with the optional feature)

Ports:
- iClk  in  1  clock
- iResetn  in  1  reset
- iByte  in  8  received PS/2 byte
- iByteValid  in  1  one-cycle strobe, iByte valid
- oX_cell  out  UPPER_BITS(6)  cell column, 0..CELLS_X-1 (63)
- oY_cell  out  UPPER_BITS(6)  cell row, 0..CELLS_Y-1 (47)
- oLeft  out  1  left button level
- oRight  out  1  right button level
- oUpdate  out  1  one-cycle pulse, new position and buttons stable
- oDrop  out  1  one-cycle pulse, packet discarded because the block was busy

Behaviour:
- Reset: iResetn, asynchronous, active-low; clock iClk. All outputs reset to 0; accumulators reset to 0; FSM resets to B0.
- Derived constants:
  - CELLS_X = SCREEN_WIDTH / CELL_DIMENSION
  - CELLS_Y = SCREEN_HEIGHT / CELL_DIMENSION
  - UPPER_BITS = clog2(max(CELLS_X, CELLS_Y))
- Receive FSM states: B0, B1, B2. Advances only on iByteValid.
  - B0: accept the byte only if bit3 = 1, else discard and stay in B0. Latch sign bits [5:4], overflow bits [7:6], buttons [1:0].
  - B1: latch the X byte.
  - B2: latch the Y byte, then signal packet complete and return to B0.
- Delta formation:
  - dx = {Xsign, Xbyte} as 9-bit two's complement; dy likewise.
  - Overflow bit set → that axis saturates to +255 or -256 per its sign bit.
  - Screen Y is inverted: sy = -dy, computed at 10 bits.
- Step engine states: IDLE, LOAD, STEP. Accumulators accX and accY are 10-bit signed.
  - Packet complete in IDLE (cycle N) → LOAD at N+1: acc += delta, buttons captured into a shadow register.
  - STEP, per cycle, per axis independently:
    - acc >= CELL_COUNTS → acc -= CELL_COUNTS, cell += 1.
    - acc <= -CELL_COUNTS → acc += CELL_COUNTS, cell -= 1.
  - When both axes satisfy |acc| < CELL_COUNTS: oLeft/oRight take the shadow value, oUpdate pulses, engine returns to IDLE.
  - Latency: oUpdate at N+2+k, where k = number of step cycles needed (max over both axes).
- Edge clamp: a step that would go past 0 or CELLS-1 does not change the cell and zeroes that axis accumulator.
- Packet completing while the engine is not IDLE: packet discarded, oDrop pulses, cell/acc/buttons untouched. The receive FSM continues normally.
- Byte strobe arriving in the same cycle as the engine's oUpdate is handled normally by the receive FSM.
- Reset mid-packet or mid-step: everything returns to reset values immediately; the partial packet is lost.
- Middle button ignored.

Optional Feature:
- MOUSE_TIMEOUT_EN defined:
  - A gap counter runs while the receive FSM is in B1 or B2 and clears on each iByteValid.
  - Reaching TIMEOUT_CYCLES forces the FSM to B0 with no packet complete and no oDrop.
- MOUSE_TIMEOUT_EN undefined: no counter; resync relies solely on the bit3 check in B0.

Decomposition:
- Shared package:
  - CELLS_X, CELLS_Y, UPPER_BITS, shared with the drawing datapath.
  - PS/2 header bit positions (YOVF=7, XOVF=6, YSIGN=5, XSIGN=4, SYNC=3, RIGHT=1, LEFT=0).
  - Receive FSM and step-engine state encodings.
- One sub-module, ps2_packet_assembler: contains the B0-B2 FSM plus the optional timeout, and outputs dx, dy, buttons, and a packet-complete strobe.

Test Plan:
- Reset, then idle → oX_cell=0, oY_cell=0, oLeft=oRight=0, oUpdate never pulses.
- Bytes 0x08, 0x10, 0x00 → dx=+16; oUpdate exactly at N+4; oX_cell=2, accX=0, oY_cell=0.
- From (0,0): 0x28, 0x00, 0xF0 (dy=-16) → oY_cell=2. Then 0x08, 0x00, 0x18 (dy=+24) → oY_cell clamps to 0, accY=0.
- Byte 0x00, then 0x09, 0x05, 0x00 → first byte dropped; oLeft=1, oX_cell unchanged, accX=5, one oUpdate. Then 0x08, 0x03, 0x00 → oX_cell=1, oLeft=0.
- Twenty packets 0x48, 0xFF, 0x00 (X overflow) → oX_cell saturates at 63. A second packet completing during STEP → oDrop pulses once, final position unaffected.
- With MOUSE_TIMEOUT_EN and TIMEOUT_CYCLES=50: 0x08, 0x10, idle 60 cycles, then 0x08, 0x08, 0x00 → oX_cell=1, one oUpdate. Same stimulus without the macro → misaligned packet is accepted (regression check of documented behaviour).
